// File: rtl/alien_formation_ctrl_pkg.sv
// Shared geometry and phase encoding for the alien formation controller.
package alien_formation_ctrl_pkg;
  localparam int COLS        = 8;
  localparam int ROWS        = 4;
  localparam int CELL_PITCH  = 32;
  localparam int SPRITE_SIZE = 16;
  localparam int NCELLS      = COLS * ROWS;
  // Formation extent measured from the origin to the far sprite edge / last row top.
  localparam int GRID_W      = (COLS - 1) * CELL_PITCH + SPRITE_SIZE;  // 240
  localparam int GRID_H      = (ROWS - 1) * CELL_PITCH;                // 96

  localparam logic [1:0] PH_IDLE    = 2'b00;
  localparam logic [1:0] PH_MARCH   = 2'b01;
  localparam logic [1:0] PH_CLEARED = 2'b10;
  localparam logic [1:0] PH_LANDED  = 2'b11;

  function automatic logic [4:0] cell_idx(input logic [1:0] row, input logic [2:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/alien_formation_ctrl_if.sv
// Hit request/ack and per-pixel cell lookup bus between game logic and the formation.
interface alien_formation_ctrl_if;
  logic       hit_valid;
  logic [2:0] hit_col;
  logic [1:0] hit_row;
  logic       hit_ack;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [9:0] cell_left_x;
  logic [9:0] cell_top_y;
  logic       cell_alive;

  modport master (
    output hit_valid, hit_col, hit_row, pix_x, pix_y,
    input  hit_ack, cell_left_x, cell_top_y, cell_alive
  );
  modport slave (
    input  hit_valid, hit_col, hit_row, pix_x, pix_y,
    output hit_ack, cell_left_x, cell_top_y, cell_alive
  );
endinterface

// File: rtl/alien_formation_ctrl_popcount.sv
// 32-bit population count used for the live-alien total.
module alien_popcount32 (
  input  logic [31:0] i_vec,
  output logic [5:0]  o_cnt
);
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < 32; i++) o_cnt = o_cnt + 6'(i_vec[i]);
  end
endmodule

// File: rtl/alien_formation_ctrl.sv
// Marches the 8x4 alien formation on frame ticks, retires hit aliens and
// resolves the cell under the current pixel for the sprite drawer.
module alien_formation_ctrl
  import alien_formation_ctrl_pkg::*;
#(
  parameter int X0          = 64,
  parameter int Y0          = 48,
  parameter int STEP_X      = 4,
  parameter int DROP_Y      = 8,
  parameter int RIGHT_LIMIT = 624,
  parameter int LEFT_LIMIT  = 16,
  parameter int FLOOR_Y     = 400,
  parameter int STEP_FRAMES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_tick,
  input  logic                  start,
  alien_formation_ctrl_if.slave bus,
  output logic [5:0]            alive_count,
  output logic [1:0]            phase
);
  localparam logic [9:0] LX0    = 10'(X0);
  localparam logic [9:0] LY0    = 10'(Y0);
  localparam logic [9:0] LSTEP  = 10'(STEP_X);
  localparam logic [9:0] LDROP  = 10'(DROP_Y);
  localparam logic [9:0] LRIGHT = 10'(RIGHT_LIMIT);
  localparam logic [9:0] LLEFT  = 10'(LEFT_LIMIT);
  localparam logic [9:0] LFLOOR = 10'(FLOOR_Y);
  localparam logic [9:0] LGW    = 10'(GRID_W);
  localparam logic [9:0] LGH    = 10'(GRID_H);
  // Frame counter is 4 bits wide, so STEP_FRAMES may not exceed 16.
  localparam logic [3:0] LPER_SLOW = 4'(STEP_FRAMES - 1);
  localparam logic [3:0] LPER_FAST = 4'(STEP_FRAMES / 2 - 1);

  logic [9:0]  r_ox, r_oy;
  logic        r_dir_left;
  logic [31:0] r_alive;
  logic [3:0]  r_fcnt;
  logic [1:0]  r_phase;
  logic        r_hit_ack;

  logic [5:0]  w_count;
  logic [3:0]  w_per_m1;
  logic        w_cleared, w_landed, w_step, w_edge, w_hit;
  logic [4:0]  w_hidx;
  logic [9:0]  w_dx, w_dy;
  logic [4:0]  w_dxq, w_dyq;
  logic        w_in;
  logic [2:0]  w_col;
  logic [1:0]  w_row;

  alien_popcount32 u_pop (.i_vec(r_alive), .o_cnt(w_count));

  always_comb begin
    w_per_m1  = (w_count > 6'd8) ? LPER_SLOW : LPER_FAST;
    w_cleared = (r_alive == '0);
    w_landed  = (r_oy + LGH >= LFLOOR);
    // >= rather than == so a counter left above a freshly shortened period still steps.
    w_step    = frame_tick && (r_fcnt >= w_per_m1);
    w_edge    = r_dir_left ? (r_ox - LSTEP < LLEFT) : (r_ox + LSTEP + LGW > LRIGHT);
    w_hidx    = cell_idx(bus.hit_row, bus.hit_col);
    w_hit     = bus.hit_valid && r_alive[w_hidx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ox       <= LX0;
      r_oy       <= LY0;
      r_dir_left <= 1'b0;
      r_alive    <= '1;
      r_fcnt     <= '0;
      r_phase    <= PH_IDLE;
      r_hit_ack  <= 1'b0;
    end else begin
      r_hit_ack <= 1'b0;
      if (start) begin
        r_ox       <= LX0;
        r_oy       <= LY0;
        r_dir_left <= 1'b0;
        r_alive    <= '1;
        r_fcnt     <= '0;
        r_phase    <= PH_MARCH;
      end else if (r_phase == PH_MARCH) begin
        if (w_cleared)      r_phase <= PH_CLEARED;
        else if (w_landed)  r_phase <= PH_LANDED;
        else begin
          if (frame_tick) r_fcnt <= w_step ? 4'd0 : r_fcnt + 4'd1;
          if (w_step) begin
            if (w_edge) begin
              r_oy       <= r_oy + LDROP;
              r_dir_left <= ~r_dir_left;
            end else begin
              r_ox <= r_dir_left ? r_ox - LSTEP : r_ox + LSTEP;
            end
          end
          if (w_hit) begin
            r_alive[w_hidx] <= 1'b0;
            r_hit_ack       <= 1'b1;
          end
        end
      end
    end
  end

  // Cell under the pixel: the 256x128 window from the origin, 32 px per cell.
  always_comb begin
    w_dx  = bus.pix_x - r_ox;
    w_dy  = bus.pix_y - r_oy;
    w_dxq = 5'(w_dx >> 5);
    w_dyq = 5'(w_dy >> 5);
    w_in  = (w_dxq[4:3] == 2'b00) && (w_dyq[4:2] == 3'b000);
    w_col = w_dxq[2:0];
    w_row = w_dyq[1:0];
    bus.cell_left_x = w_in ? r_ox + {2'b00, w_col, 5'b0} : r_ox;
    bus.cell_top_y  = w_in ? r_oy + {3'b000, w_row, 5'b0} : r_oy;
    bus.cell_alive  = w_in && r_alive[cell_idx(w_row, w_col)] && (r_phase == PH_MARCH);
  end

  assign bus.hit_ack  = r_hit_ack;
  assign alive_count  = w_count;
  assign phase        = r_phase;
endmodule

// File: tb/tb_alien_formation_ctrl.sv
// Randomized and directed checks of alien_formation_ctrl against a behavioural model.
module tb_alien_formation_ctrl;
  logic clk, rst_n, frame_tick, start;
  logic [5:0] alive_count;
  logic [1:0] phase;
  alien_formation_ctrl_if bus();

  alien_formation_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .bus(bus), .alive_count(alive_count), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // behavioural model of the formation
  int m_x, m_y, m_cnt, m_ph;
  bit m_left, m_ack;
  bit [31:0] m_alive;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, exp);
  endtask

  task automatic wave_init(input int ph);
    m_x = 64; m_y = 48; m_left = 0; m_alive = '1; m_cnt = 0; m_ph = ph;
  endtask

  task automatic march_step();
    if (!m_left) begin
      if (m_x + 4 + 240 > 624) begin m_y += 8; m_left = 1; end
      else m_x += 4;
    end else begin
      if (m_x - 4 < 16) begin m_y += 8; m_left = 0; end
      else m_x -= 4;
    end
  endtask

  task automatic upd(input int r, s, ft, hv, hc, hr);
    int per, idx;
    bit ack;
    ack = 0;
    if (r == 0) wave_init(0);
    else if (s != 0) wave_init(1);
    else if (m_ph == 1) begin
      if (m_alive == 0) m_ph = 2;
      else if (m_y + 96 >= 400) m_ph = 3;
      else begin
        per = ($countones(m_alive) > 8) ? 16 : 8;
        idx = hr * 8 + hc;
        if (ft != 0) begin
          if (m_cnt + 1 >= per) begin m_cnt = 0; march_step(); end
          else m_cnt++;
        end
        if (hv != 0 && m_alive[idx]) begin m_alive[idx] = 0; ack = 1; end
      end
    end
    m_ack = ack;
  endtask

  task automatic chk_all();
    int dx, dy, el, et, ea;
    dx = (int'(bus.pix_x) - m_x) & 1023;
    dy = (int'(bus.pix_y) - m_y) & 1023;
    if (dx < 256 && dy < 128) begin
      el = (m_x + (dx / 32) * 32) & 1023;
      et = (m_y + (dy / 32) * 32) & 1023;
      ea = (m_alive[(dy / 32) * 8 + dx / 32] && m_ph == 1) ? 1 : 0;
    end else begin
      el = m_x; et = m_y; ea = 0;
    end
    chk("phase", phase, m_ph);
    chk("count", alive_count, $countones(m_alive));
    chk("ack", bus.hit_ack, m_ack);
    chk("left", bus.cell_left_x, el);
    chk("top", bus.cell_top_y, et);
    chk("calive", bus.cell_alive, ea);
  endtask

  task automatic cyc(input int r, s, ft, hv, hc, hr, px, py);
    @(negedge clk);
    rst_n = r[0]; start = s[0]; frame_tick = ft[0];
    bus.hit_valid = hv[0]; bus.hit_col = 3'(hc); bus.hit_row = 2'(hr);
    bus.pix_x = 10'(px); bus.pix_y = 10'(py);
    #1 chk_all();
    @(posedge clk);
    upd(r, s, ft, hv, hc, hr);
  endtask

  task automatic tick(input int n);
    repeat (n) cyc(1, 0, 1, 0, 0, 0, 0, 0);
  endtask
  task automatic hit(input int c, r);
    cyc(1, 0, 0, 1, c, r, 0, 0);
  endtask

  initial begin
    int guard;
    rst_n = 0; start = 0; frame_tick = 0;
    bus.hit_valid = 0; bus.hit_col = 0; bus.hit_row = 0; bus.pix_x = 0; bus.pix_y = 0;
    repeat (3) @(posedge clk);
    upd(0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_phase", phase, 0);
    chk("rst_count", alive_count, 32);
    chk("rst_ack", bus.hit_ack, 0);
    chk("rst_left", bus.cell_left_x, 64);

    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    #2 chk("start_phase", phase, 1);
    tick(16);
    #2 chk("x68", bus.cell_left_x, 68);
    tick(79 * 16);
    #2 chk("x384", bus.cell_left_x, 384);
    tick(16);
    #2 chk("drop_x", bus.cell_left_x, 384);
    chk("drop_y", bus.cell_top_y, 56);
    tick(16);
    #2 chk("x380", bus.cell_left_x, 380);

    hit(3, 2);
    #2 chk("hit_ack", bus.hit_ack, 1);
    chk("hit_cnt", alive_count, 31);
    hit(3, 2);
    #2 chk("rehit_ack", bus.hit_ack, 0);
    chk("rehit_cnt", alive_count, 31);

    for (int i = 0; i < 32; i++)
      if ($countones(m_alive) > 8 && m_alive[i]) hit(i % 8, i / 8);
    #2 chk("cnt8", alive_count, 8);
    tick(7);
    #2 chk("fast_hold", bus.cell_left_x, 380);
    tick(1);
    #2 chk("fast_step", bus.cell_left_x, 376);

    for (int i = 24; i < 32; i++) hit(i % 8, i / 8);
    #2 chk("cnt0", alive_count, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    #2 chk("cleared", phase, 2);
    tick(20);
    #2 chk("frz_x", bus.cell_left_x, 376);
    chk("frz_y", bus.cell_top_y, 56);

    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 0, 0, 0);
    #2 chk("st_hit_ack", bus.hit_ack, 0);
    chk("st_hit_cnt", alive_count, 32);

    cyc(1, 0, 0, 0, 0, 0, 100, 80);
    #2 chk("pix_left", bus.cell_left_x, 96);
    chk("pix_top", bus.cell_top_y, 80);
    chk("pix_alive", bus.cell_alive, 1);
    cyc(1, 0, 0, 0, 0, 0, 320, 80);
    #2 chk("pix_out", bus.cell_alive, 0);

    for (int i = 0; i < 28; i++) hit(i % 8, i / 8);
    guard = 0;
    while (m_ph != 3 && guard < 40000) begin tick(1); guard++; end
    #2 chk("landed", phase, 3);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    #2 chk("re_phase", phase, 1);
    chk("re_cnt", alive_count, 32);
    chk("re_x", bus.cell_left_x, 64);
    chk("re_y", bus.cell_top_y, 48);

    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 199) != 0) ? 1 : 0, ($urandom_range(0, 79) == 0) ? 1 : 0,
          $urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 1 : 0,
          $urandom_range(0, 7), $urandom_range(0, 3),
          $urandom_range(0, 1023), $urandom_range(0, 1023));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
